dsp_addsub_arbiter: RTL and testbench
=====================================

// Module: dsp_addsub_arbiter
// PURPOSE
//  Shares one combinational DSP add/sub unit (SB_MAC16 wrapper) between two requesters in sail-core.
//  Requesters are, for example, the ALU and the branch-target adder.
//  Grants by round-robin, holds operands stable for a settle window, registers the result and carry,
//  and returns them through a valid/ready response port tagged with the requester id.
// PARAMETERS
//  WIDTH        32  operand/result width; must be 32 to match the DSP wrapper
//  SETTLE_CYC   1   cycles operands are held on the DSP before capture; legal range 1..15
// PORTS
//  clk          in   1      system clock, all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  req0_valid   in   1      requester 0 has an operation pending
//  req0_ready   out  1      requester 0 operation accepted this cycle
//  req0_a       in   WIDTH  requester 0 operand A (minuend/augend)
//  req0_b       in   WIDTH  requester 0 operand B (subtrahend/addend)
//  req0_sub     in   1      1 = A-B, 0 = A+B
//  req1_valid/req1_ready/req1_a/req1_b/req1_sub   same as requester 0, for requester 1
//  rsp_valid    out  1      result available
//  rsp_ready    in   1      consumer accepts result
//  rsp_id       out  1      id of requester that owns the result
//  rsp_result   out  WIDTH  registered DSP result
//  rsp_carry    out  1      registered DSP carry-out
//  dsp_in1      out  WIDTH  to DSP input1 (A)
//  dsp_in2      out  WIDTH  to DSP input2 (B)
//  dsp_sub      out  1      to DSP add/sub select
//  dsp_out      in   WIDTH  from DSP result
//  dsp_co       in   1      from DSP carry_out
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE:
//    - a request with valid=1 is granted: reqN_ready=1 for exactly that cycle (combinational from state/valids).
//    - A, B, sub and id are latched; the FSM enters EXEC with cnt=SETTLE_CYC-1.
//  - Arbitration when both valid: grant the requester NOT granted last. One valid: grant it, no fairness penalty.
//  - Last-grant pointer resets to 1, so requester 0 wins the first tie.
//  - EXEC:
//    - dsp_in1/dsp_in2/dsp_sub driven from the latched operands; cnt decrements each cycle.
//    - When cnt==0: capture dsp_out->rsp_result and dsp_co->rsp_carry, then go to RESP.
//  - RESP: rsp_valid=1, all outputs held stable until rsp_valid&rsp_ready; then go to IDLE.
//  - No grant in the cycle of the response handshake; the earliest next grant is the following cycle.
//  - Latency: grant in cycle N, rsp_valid from cycle N+1+SETTLE_CYC.
//    With SETTLE_CYC=1: grant N, rsp_valid N+2. Minimum issue interval SETTLE_CYC+2 cycles.
//  - reqN_ready is 0 in EXEC and RESP; reqN_ready is never asserted for both requesters in one cycle.
//  - Requester must hold valid and operands until its ready; dropping valid before ready aborts nothing.
//  - Outside EXEC, dsp_in1/dsp_in2/dsp_sub hold their last latched values (no glitching to the DSP).
//  - Arithmetic: add = (A+B) mod 2^32; sub = (A-B) mod 2^32.
//    rsp_carry is the raw DSP carry: add=carry out of bit 31; sub=1 when no borrow (A>=B unsigned).
//  - Reset, including mid-EXEC or mid-RESP:
//    - in-flight op discarded; state=IDLE; rsp_valid=0; req0_ready=req1_ready=0.
//    - rsp_id=0, rsp_result=0, rsp_carry=0, dsp_in1=dsp_in2=0, dsp_sub=0; last-grant pointer=1; cnt=0.
//  - Reset has priority over every handshake in the same cycle.
// CONFIGURATION
//  DSP_ARB_STATS_EN defined:
//   - adds outputs grant_cnt0[15:0] and grant_cnt1[15:0].
//   - each counter increments on its requester's grant and saturates at 16'hFFFF.
//   - both counters clear to 0 on reset.
//  DSP_ARB_STATS_EN undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  1. Reset 2 cycles, no requests -> rsp_valid=0, both ready=0, dsp_in1=0 throughout.
//  2. req0 A=32'h0000_0005 B=32'h0000_0003 sub=1, rsp_ready=1
//     -> ready0 at N, rsp_valid at N+2, result=2, carry=1, id=0.
//  3. req1 A=32'hFFFF_FFFF B=32'h1 sub=0 -> result=0, carry=1, id=1.
//     Then A=3 B=5 sub=1 -> result=32'hFFFF_FFFE, carry=0.
//  4. Both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1.
//     No cycle has both readys high; rsp_id sequence matches.
//  5. rsp_ready held 0 for 5 cycles in RESP -> result/id/carry stable, no new grant.
//     Release -> next grant one cycle after the handshake.
//  6. Assert reset during EXEC -> next cycle rsp_valid=0, outputs at reset values.
//     With DSP_ARB_STATS_EN: counters=0 after reset; after 3 req0 grants grant_cnt0=3.

Source files
------------

// File: rtl/dsp_addsub_arbiter.sv
// Round-robin arbiter sharing one combinational DSP add/sub unit between two requesters.
// Optional grant statistics outputs are enabled by defining DSP_ARB_STATS_EN.
module dsp_addsub_arbiter #(
  parameter int WIDTH      = 32,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic [WIDTH-1:0] dsp_in1,
  output logic [WIDTH-1:0] dsp_in2,
  output logic             dsp_sub,
  input  logic [WIDTH-1:0] dsp_out,
  input  logic             dsp_co
`ifdef DSP_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic             last_grant_q;
  logic [3:0]       cnt_q;
  logic             grant0, grant1, capture;
  logic [WIDTH-1:0] op_a_p0, op_b_p0;
  logic             op_sub_p0, op_id_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] result_p1;
  logic             carry_p1, id_p1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Tie goes to whoever was not granted last; a lone requester always wins.
        if (!reset) begin
          grant0 = req0_valid && (!req1_valid || last_grant_q);
          grant1 = req1_valid && (!req0_valid || !last_grant_q);
        end
        if (grant0 || grant1) state_d = EXEC;
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Stage p0: operands latched at grant, held on the DSP until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      op_a_p0      <= '0;
      op_b_p0      <= '0;
      op_sub_p0    <= 1'b0;
      op_id_p0     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        op_a_p0      <= grant1 ? req1_a : req0_a;
        op_b_p0      <= grant1 ? req1_b : req0_b;
        op_sub_p0    <= grant1 ? req1_sub : req0_sub;
        op_id_p0     <= grant1;
        last_grant_q <= grant1;
        cnt_q        <= CNT_INIT;
      end else if (state_q == EXEC && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign dsp_in1 = op_a_p0;
  assign dsp_in2 = op_b_p0;
  assign dsp_sub = op_sub_p0;

  // Stage p1: DSP result captured at the end of the settle window.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_p1 <= '0;
      carry_p1  <= 1'b0;
      id_p1     <= 1'b0;
    end else if (capture) begin
      result_p1 <= dsp_out;
      carry_p1  <= dsp_co;
      id_p1     <= op_id_p0;
    end
  end

  assign vld_p1     = (state_q == RESP);
  assign rsp_valid  = vld_p1;
  assign rsp_result = result_p1;
  assign rsp_carry  = carry_p1;
  assign rsp_id     = id_p1;

`ifdef DSP_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (grant0) grant_cnt0 <= sat_inc16(grant_cnt0);
      if (grant1) grant_cnt1 <= sat_inc16(grant_cnt1);
    end
  end
`else
  logic unused_sat;
  assign unused_sat = ^sat_inc16(16'd0);
`endif

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Directed bench for dsp_addsub_arbiter with a behavioural DSP add/sub model.
module tb_dsp_addsub_arbiter;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             req0_valid, req0_ready, req0_sub;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_sub;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [WIDTH-1:0] rsp_result;
  logic [WIDTH-1:0] dsp_in1, dsp_in2, dsp_out;
  logic             dsp_sub, dsp_co;
  logic [WIDTH:0]   dsp_sum;
`ifdef DSP_ARB_STATS_EN
  logic [15:0]      grant_cnt0, grant_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dsp_addsub_arbiter #(.WIDTH(WIDTH), .SETTLE_CYC(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .dsp_in1    (dsp_in1),
    .dsp_in2    (dsp_in2),
    .dsp_sub    (dsp_sub),
    .dsp_out    (dsp_out),
    .dsp_co     (dsp_co)
`ifdef DSP_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // Behavioural DSP: subtract as A + ~B + 1 so carry means "no borrow".
  always_comb begin
    if (dsp_sub) dsp_sum = {1'b0, dsp_in1} + {1'b0, ~dsp_in2} + 33'd1;
    else         dsp_sum = {1'b0, dsp_in1} + {1'b0, dsp_in2};
  end
  assign dsp_out = dsp_sum[WIDTH-1:0];
  assign dsp_co  = dsp_sum[WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single isolated operation; starts and ends in IDLE with rsp_ready=1.
  task automatic op1(input int rq, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] er, input logic ec);
    @(negedge clk);
    if (rq == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = s;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = s;
    end
    rsp_ready = 1'b1;
    #1;
    chk("op_rdy", 32'(rq == 0 ? req0_ready : req1_ready), 1);
    chk("op_rdy_other", 32'(rq == 0 ? req1_ready : req0_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("op_exec_rv", 32'(rsp_valid), 0);
    chk("op_exec_rdy", 32'(req0_ready | req1_ready), 0);
    chk("op_dsp_in1", dsp_in1, a);
    chk("op_dsp_in2", dsp_in2, b);
    chk("op_dsp_sub", 32'(dsp_sub), 32'(s));
    @(negedge clk);
    #1;
    chk("op_rsp_rv", 32'(rsp_valid), 1);
    chk("op_rsp_result", rsp_result, er);
    chk("op_rsp_carry", 32'(rsp_carry), 32'(ec));
    chk("op_rsp_id", 32'(rsp_id), rq);
    @(negedge clk);
    #1;
    chk("op_idle_rv", 32'(rsp_valid), 0);
    chk("op_idle_hold", dsp_in1, a);
  endtask

  initial begin
    int grants, resps;
    logic drop;
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    rsp_ready = 1'b0;

    // Reset with no requests
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("t1_rv", 32'(rsp_valid), 0);
      chk("t1_rdy0", 32'(req0_ready), 0);
      chk("t1_rdy1", 32'(req1_ready), 0);
      chk("t1_dsp_in1", dsp_in1, 0);
    end
    reset = 1'b0;

    // Basic subtract, add with wrap, subtract with borrow
    op1(0, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1);
    op1(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    op1(1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0);

    // Both requesters valid continuously: grants alternate starting with 0
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1; req1_sub = 1'b1;
    rsp_ready = 1'b1;
    grants = 0; resps = 0; drop = 1'b0;
    for (int cyc = 0; cyc < 60 && resps < 6; cyc++) begin
      #1;
      chk("t4_one_rdy", 32'(req0_ready & req1_ready), 0);
      if (req0_ready | req1_ready) begin
        chk("t4_grant_id", 32'(req1_ready), 32'(grants % 2));
        grants++;
        if (grants == 6) drop = 1'b1;
      end
      if (rsp_valid) begin
        chk("t4_rsp_id", 32'(rsp_id), 32'(resps % 2));
        chk("t4_rsp_result", rsp_result, (resps % 2 == 1) ? 32'd99 : 32'd101);
        resps++;
      end
      @(negedge clk);
      if (drop) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    chk("t4_grants", 32'(grants), 6);
    chk("t4_resps", 32'(resps), 6);

    // Back-pressure on the response port
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd2; req0_sub = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("t5_rdy0", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sub = 1'b0;
    #1;
    chk("t5_exec_rdy1", 32'(req1_ready), 0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_hold_rv", 32'(rsp_valid), 1);
      chk("t5_hold_result", rsp_result, 32'd9);
      chk("t5_hold_id", 32'(rsp_id), 0);
      chk("t5_hold_carry", 32'(rsp_carry), 0);
      chk("t5_hold_rdy1", 32'(req1_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_hs_rv", 32'(rsp_valid), 1);
    chk("t5_hs_rdy1", 32'(req1_ready), 0);
    @(negedge clk);
    #1;
    chk("t5_next_rv", 32'(rsp_valid), 0);
    chk("t5_next_rdy1", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_r1_rv", 32'(rsp_valid), 1);
    chk("t5_r1_result", rsp_result, 32'd2);
    chk("t5_r1_id", 32'(rsp_id), 1);
    @(negedge clk);

    // Reset during EXEC, with requests pending during reset
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_sub = 1'b1;
    #1;
    chk("t6_rdy0", 32'(req0_ready), 1);
    @(negedge clk);
    #1;
    chk("t6_exec_in1", dsp_in1, 32'd5);
    reset = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_sub = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_rst_rv", 32'(rsp_valid), 0);
    chk("t6_rst_rdy0", 32'(req0_ready), 0);
    chk("t6_rst_rdy1", 32'(req1_ready), 0);
    chk("t6_rst_in1", dsp_in1, 0);
    chk("t6_rst_in2", dsp_in2, 0);
    chk("t6_rst_sub", 32'(dsp_sub), 0);
    chk("t6_rst_result", rsp_result, 0);
    chk("t6_rst_id", 32'(rsp_id), 0);
`ifdef DSP_ARB_STATS_EN
    chk("t6_rst_cnt0", 32'(grant_cnt0), 0);
    chk("t6_rst_cnt1", 32'(grant_cnt1), 0);
`endif
    reset = 1'b0;
    #1;
    chk("t6_tie_rdy0", 32'(req0_ready), 1);
    chk("t6_tie_rdy1", 32'(req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_r_rv", 32'(rsp_valid), 1);
    chk("t6_r_result", rsp_result, 32'd2);
    chk("t6_r_carry", 32'(rsp_carry), 1);
    @(negedge clk);
    op1(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
    op1(0, 32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0000, 1'b1);
`ifdef DSP_ARB_STATS_EN
    chk("t6_cnt0", 32'(grant_cnt0), 3);
    chk("t6_cnt1", 32'(grant_cnt1), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
